instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the RV32IM single-cycle core. Holds the program counter, drives the word-indexed instruction ROM address, captures the returned instruction word, and buffers it in a small FIFO. The decode stage drains it through a valid/ready handshake. Branch and jump redirects from execute flush the buffer and reload the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: byte address loaded into the PC on reset. Must be word aligned.
- FIFO_DEPTH, 2: instruction buffer entries. Legal values are 2..8.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rom_addr_o  out  32  ROM word index, always equal to {2'b00, pc[31:2]}.
- rom_data_i  in  32  instruction word returned by the ROM in the same cycle (combinational read).
- redirect_i  in  1  taken branch or jump from execute.
- redirect_pc_i  in  32  byte target of the redirect.
- instr_valid_o  out  1  FIFO head holds an instruction.
- instr_ready_i  in  1  decode accepts the head.
- instr_o  out  32  FIFO head instruction.
- instr_pc_o  out  32  byte PC of the FIFO head.
- fault_o  out  1  sticky flag for a misaligned redirect target.

## Operation
- State machine has two states:
  - RUN: the only state entered from reset.
  - FAULT: entered only via a misaligned redirect; left only via rst.
- Push condition: push = RUN && !redirect_i && count < FIFO_DEPTH.
  - The entry {pc, rom_data_i} is written at the tail.
  - pc advances by 4 (32-bit modulo; 32'hFFFF_FFFC wraps to 0).
  - A full FIFO is never written, even if a pop occurs in the same cycle.
- Pop condition: pop = instr_valid_o && instr_ready_i. Removes the head.
- Simultaneous push and pop leaves count unchanged.
- Redirect with an aligned target (redirect_pc_i[1:0] == 0):
  - FIFO is flushed (count set to 0), overriding any pop.
  - pc is set to redirect_pc_i.
  - No push occurs that cycle.
- Redirect with a misaligned target:
  - FIFO is flushed, pc holds its value, fault_o is set, state goes to FAULT.
- In FAULT:
  - No pushes; pc is frozen; redirect_i is ignored.
  - instr_valid_o stays 0; rom_addr_o holds its value.
- Counter and pointer widths:
  - count is clog2(FIFO_DEPTH)+1 bits.
  - Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- instr_o and instr_pc_o are driven from registered storage. Their value is don't-care while instr_valid_o = 0.

## Timing
- Reset values:
  - pc = RESET_PC, so rom_addr_o = RESET_PC>>2.
  - count = 0, so instr_valid_o = 0.
  - fault_o = 0, state = RUN.
  - instr_o = 0, instr_pc_o = 0.
- Latency: a word pushed at edge N appears at instr_o after edge N, i.e. one cycle from ROM read to decode visibility.
  - After rst deasserts, the first instr_valid_o = 1 follows the first rising edge.
- Throughput: with instr_ready_i held at 1, one instruction per cycle and count settles at 1.
- Redirect at edge N:
  - instr_valid_o = 0 during cycle N+1.
  - The target instruction becomes valid in cycle N+2.
- rst asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Decode handshake: instr_o and instr_pc_o are stable while valid && !ready. valid is never withdrawn except by a redirect or a fault.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds perf_fetch_o (out, 32): counts pushes.
  - Adds perf_stall_o (out, 32): counts RUN cycles with count == FIFO_DEPTH.
  - Both reset to 0, wrap at 2^32, and freeze in FAULT.
- Undefined: neither port nor counter exists, and all behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC = 0 and instr_ready_i = 1:
  - Before the first edge: rom_addr_o = 0, 1, 2, 3 on successive cycles; instr_valid_o = 0 and fault_o = 0.
  - Afterwards: instr_pc_o = 0, 4, 8 on successive cycles, with instr_o matching the ROM words.
- Backpressure: hold instr_ready_i = 0 for 5 cycles.
  - count saturates at 2 and the head stays at pc 0.
  - rom_addr_o holds at 2.
  - On release, pcs 0, 4, 8 are delivered with no gap and no duplicates.
- Redirect to 32'h0000_0010 while the FIFO holds 2 entries:
  - Next cycle: instr_valid_o = 0.
  - The cycle after: instr_pc_o = 0x10.
  - Stale pcs never appear.
- Redirect to 32'h0000_0012:
  - fault_o = 1 and instr_valid_o = 0 permanently.
  - Later aligned redirects are ignored.
  - Asserting rst clears fault_o to 0.
- Wrap and async reset:
  - Redirect to 32'hFFFF_FFFC: the next pushed pc is 0.
  - Asserting rst between edges clears instr_valid_o to 0 within the same cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM addressing and a small instruction buffer drained by decode.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic               fault_reg, fault_next;
  logic               push, pop, full;

  logic [31:0]        data_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full          = (count_reg == CNT_W'(FIFO_DEPTH));
  assign instr_valid_o = (state_reg == RUN) && (count_reg != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign rom_addr_o    = {2'b00, pc_reg[31:2]};
  assign instr_o       = data_mem[rd_ptr_reg];
  assign instr_pc_o    = pc_mem[rd_ptr_reg];
  assign fault_o       = fault_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    fault_next  = fault_reg;
    push        = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect_i) begin
          // A redirect flushes the buffer and wins over any pop this cycle.
          count_next  = '0;
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          if (redirect_pc_i[1:0] == 2'b00) begin
            pc_next = redirect_pc_i;
          end else begin
            state_next = FAULT;
            fault_next = 1'b1;
          end
        end else begin
          // A full buffer is never written, even when the head leaves this cycle.
          push = !full;
          if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
            pc_next     = pc_reg + 32'd4;
          end
          if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
          end
          count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      fault_reg  <= fault_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage is cleared on reset so the head reads as zero before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) begin
          data_mem[i] <= rom_data_i;
          pc_mem[i]   <= pc_reg;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_reg, perf_stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (push) begin
        perf_fetch_reg <= perf_fetch_reg + 32'd1;
      end
      if ((state_reg == RUN) && full) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetch_o = perf_fetch_reg;
  assign perf_stall_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected PCs are queued by the stimulus
// and a negedge monitor checks every decode handshake against them.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid),
    .instr_ready_i(ready),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .fault_o      (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch),
    .perf_stall_o (perf_stall)
`endif
  );

  // ROM contents are a fixed function of the word index.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the next queued PC and its ROM word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn_pc", instr_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] txn pc=0x%08h instr=0x%08h", instr_pc, instr);
          check("txn_pc", instr_pc, e);
          check("txn_instr", instr, rom_word({2'b00, e[31:2]}));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;

    // Reset state and streaming with ready held high.
    #2;
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("c0_rom_addr", rom_addr, 32'h0);
    check("c0_valid", 32'(valid), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("stream_rom_addr", rom_addr, 32'(k));
    end
    tick();
    tick();
    ready = 1'b0;
    check("p0_drained", 32'(exp_q.size()), 32'h0);

    // Backpressure: buffer fills to 2 and the PC stalls.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
    check("bp_rom_addr", rom_addr, 32'h2);
    check("bp_valid", 32'(valid), 32'h1);
    check("bp_head_pc", instr_pc, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_no_gap", 32'(valid), 32'h1);
    end
    tick();
    ready = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'h0);

    // Aligned redirect with a full buffer.
    tick();
    check("pre_redir_valid", 32'(valid), 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    redirect = 1'b0;
    check("redir_n1_valid", 32'(valid), 32'h0);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    ready = 1'b1;
    tick();
    check("redir_n2_valid", 32'(valid), 32'h1);
    check("redir_n2_pc", instr_pc, 32'h10);
    repeat (3) tick();
    ready = 1'b0;
    check("redir_drained", 32'(exp_q.size()), 32'h0);
    check("redir_rom_addr", rom_addr, 32'h8);

    // Misaligned redirect enters FAULT; later redirects are ignored.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0012;
    tick();
    redirect = 1'b0;
    ready = 1'b1;
    check("fault_set", 32'(fault), 32'h1);
    check("fault_valid", 32'(valid), 32'h0);
    check("fault_rom_addr", rom_addr, 32'h8);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    check("fault_sticky", 32'(fault), 32'h1);
    check("fault_valid_hold", 32'(valid), 32'h0);
    check("fault_rom_addr_hold", rom_addr, 32'h8);
    #2;
    rst = 1'b1;
    ready = 1'b0;
    #1;
    check("fault_cleared", 32'(fault), 32'h0);
    check("fault_rst_rom_addr", rom_addr, 32'h0);

    // PC wrap after a redirect to the top word, then asynchronous reset.
    @(negedge clk);
    rst = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_top_addr", rom_addr, 32'h3FFF_FFFF);
    tick();
    check("wrap_addr", rom_addr, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    ready = 1'b1;
    tick();
    tick();
    check("wrap_pre_rst_valid", 32'(valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_instr_pc", instr_pc, 32'h0);
    check("async_rst_instr", instr, 32'h0);
    check("wrap_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
